// File: rtl/led_sched_pkg.sv
// Shared types for the LED pattern scheduler: FSM state encoding and code width.
package led_sched_pkg;

  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PULSE_ON  = 2'd1,
    PULSE_OFF = 2'd2,
    GAP       = 2'd3
  } state_e;

endpackage

// File: rtl/led_tick_gen.sv
// Pattern-tick prescaler: counts 0..TICK_CYCLES-1 while enabled, tick_o on the terminal count.
module led_tick_gen #(
  parameter int TICK_CYCLES = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [W-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == W'(TICK_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_scheduler.sv
// Round-robin sharing of two status LEDs between N_REQ requesters; plays one blink code
// at a time and falls back to a complementary heartbeat when idle.
module led_pattern_scheduler
  import led_sched_pkg::*;
#(
  parameter int CLK_HZ      = 78_000_000,
  parameter int TICK_HZ     = 10,
  parameter int N_REQ       = 4,
  parameter int PULSE_TICKS = 2,
  parameter int GAP_TICKS   = 10
) (
  input  logic                    CLKOS,
  input  logic                    Reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [CODE_W*N_REQ-1:0] code,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        ack,
  output logic                    busy,
  output logic                    LED1,
  output logic                    LED2
);

  localparam int TICK_CYCLES = CLK_HZ / TICK_HZ;
  localparam int HB_HALF     = CLK_HZ / 2;
  localparam int HB_W        = (HB_HALF > 1) ? $clog2(HB_HALF) : 1;
  localparam int TK_MAX      = (PULSE_TICKS > GAP_TICKS) ? PULSE_TICKS : GAP_TICKS;
  localparam int TK_W        = (TK_MAX > 1) ? $clog2(TK_MAX) : 1;
  localparam int PTR_W       = $clog2(N_REQ);

  state_e             state_q;
  logic [N_REQ-1:0]   grant_q;
  logic [N_REQ-1:0]   ack_q;
  logic               busy_q;
  logic               led1_q;
  logic               led2_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   gidx_q;
  logic [CODE_W-1:0]  code_q;
  logic [CODE_W-1:0]  pulse_q;
  logic [TK_W-1:0]    tcnt_q;
  logic [HB_W-1:0]    hb_q;

  logic               arb_vld;
  logic [PTR_W-1:0]   arb_idx;
  logic [CODE_W-1:0]  arb_code;
  logic               start;
  logic               tick;

  // Scan downward so the requester closest to (at or above) the pointer wins.
  always_comb begin
    int s;
    s       = 0;
    arb_vld = 1'b0;
    arb_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      s = int'(ptr_q) + k;
      if (s >= N_REQ) s = s - N_REQ;
      if (req[s]) begin
        arb_vld = 1'b1;
        arb_idx = PTR_W'(s);
      end
    end
    arb_code = code[CODE_W*arb_idx +: CODE_W];
    if (arb_code == '0) arb_code = CODE_W'(1);
  end

  // No arbitration in the ack cycle: the finishing requester may still hold req.
  assign start = (state_q == IDLE) && arb_vld && (ack_q == '0);

  led_tick_gen #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick (
    .clk_i  (CLKOS),
    .rst_ni (Reset_n),
    .clr_i  (start),
    .en_i   (state_q != IDLE),
    .tick_o (tick)
  );

  always_ff @(posedge CLKOS or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      led1_q  <= 1'b0;
      led2_q  <= 1'b1;
      ptr_q   <= '0;
      gidx_q  <= '0;
      code_q  <= '0;
      pulse_q <= '0;
      tcnt_q  <= '0;
      hb_q    <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (start) begin
            grant_q <= {{(N_REQ-1){1'b0}}, 1'b1} << arb_idx;
            gidx_q  <= arb_idx;
            busy_q  <= 1'b1;
            code_q  <= arb_code;
            led1_q  <= 1'b1;
            led2_q  <= 1'b1;
            pulse_q <= '0;
            tcnt_q  <= '0;
            state_q <= PULSE_ON;
          end else if (hb_q == HB_W'(HB_HALF - 1)) begin
            hb_q   <= '0;
            led1_q <= ~led1_q;
            led2_q <= ~led2_q;
          end else begin
            hb_q <= hb_q + 1'b1;
          end
        end
        PULSE_ON: if (tick) begin
          if (tcnt_q == TK_W'(PULSE_TICKS - 1)) begin
            tcnt_q  <= '0;
            led1_q  <= 1'b0;
            pulse_q <= pulse_q + 1'b1;
            state_q <= PULSE_OFF;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        PULSE_OFF: if (tick) begin
          if (tcnt_q == TK_W'(PULSE_TICKS - 1)) begin
            tcnt_q <= '0;
            if (pulse_q < code_q) begin
              led1_q  <= 1'b1;
              state_q <= PULSE_ON;
            end else begin
              state_q <= GAP;
            end
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        GAP: if (tick) begin
          if (tcnt_q == TK_W'(GAP_TICKS - 1)) begin
            tcnt_q  <= '0;
            ack_q   <= grant_q;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= (gidx_q == PTR_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
            led1_q  <= 1'b0;
            led2_q  <= 1'b1;
            hb_q    <= '0;
            state_q <= IDLE;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant = grant_q;
  assign ack   = ack_q;
  assign busy  = busy_q;
  assign LED1  = led1_q;
  assign LED2  = led2_q;

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Directed bench for led_pattern_scheduler with a 10-cycle tick, 1-tick pulses and a 3-tick gap.
module tb_led_pattern_scheduler;

  localparam int TC = 10;
  localparam int PT = 1;
  localparam int GT = 3;

  logic        CLKOS = 1'b0;
  logic        Reset_n;
  logic [3:0]  req;
  logic [15:0] code;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        busy;
  logic        LED1;
  logic        LED2;

  int n_cmp = 0;
  int n_mis = 0;

  led_pattern_scheduler #(
    .CLK_HZ      (100),
    .TICK_HZ     (10),
    .N_REQ       (4),
    .PULSE_TICKS (PT),
    .GAP_TICKS   (GT)
  ) dut (
    .CLKOS   (CLKOS),
    .Reset_n (Reset_n),
    .req     (req),
    .code    (code),
    .grant   (grant),
    .ack     (ack),
    .busy    (busy),
    .LED1    (LED1),
    .LED2    (LED2)
  );

  always #5 CLKOS = ~CLKOS;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLKOS);
    #1;
  endtask

  // Idle heartbeat over n edges counted from a state with the counter at 0 and LED1=0.
  task automatic hb_check(input string nm, input int n);
    int bad;
    bit l;
    bad = 0;
    for (int k = 1; k <= n; k++) begin
      step();
      l = ((k / 50) % 2) == 1;
      if ({ack, grant, busy, LED2, LED1} !== {4'b0, 4'b0, 1'b0, ~l, l}) bad++;
    end
    chk(nm, bad, 0);
  endtask

  // One pattern: grant expected 'gap' edges after the call, ack after the hand-computed latency.
  task automatic play(input string nm, input int gi, input int c, input int gap,
                      input int drop_at, input bit hold);
    int n, first, bad, lat;
    bit e;
    logic [3:0] gexp;
    gexp = 4'(1 << gi);
    lat  = (2 * c * PT + GT) * TC;
    n = 0;
    while (n < 20) begin
      step();
      n++;
      if (grant != 4'b0) break;
    end
    chk({nm, "_gap"}, n, gap);
    chk({nm, "_grant"}, grant, gexp);
    chk({nm, "_leds0"}, {busy, LED2, LED1}, 3'b111);
    first = 0;
    bad   = 0;
    for (int t = 1; t <= lat + 5 && first == 0; t++) begin
      if (t == drop_at) req[gi] = 1'b0;
      step();
      e = (t < 2 * c * PT * TC) && (((t / TC) % 2) == 0);
      if (ack != 4'b0) first = t;
      else if ({grant, busy, LED2, LED1} !== {gexp, 1'b1, 1'b1, e}) bad++;
    end
    chk({nm, "_ack_lat"}, first, lat);
    chk({nm, "_ack"}, ack, gexp);
    chk({nm, "_end"}, {grant, busy, LED2, LED1}, {4'b0, 1'b0, 1'b1, 1'b0});
    chk({nm, "_shape"}, bad, 0);
    if (!hold) req[gi] = 1'b0;
    step();
    chk({nm, "_ack_pulse"}, {ack, grant}, 8'h00);
  endtask

  initial begin
    int n;
    Reset_n = 1'b0;
    req     = 4'b0;
    code    = 16'h0;
    #12;
    chk("reset_state", {ack, grant, busy, LED2, LED1}, {4'b0, 4'b0, 1'b0, 1'b1, 1'b0});
    @(posedge CLKOS);
    #1 Reset_n = 1'b1;

    hb_check("heartbeat", 200);

    req  = 4'b0100;
    code = 16'h0300;
    play("code3", 2, 3, 1, 0, 1'b0);

    repeat (3) step();
    req  = 4'b1000;
    code = 16'h0000;
    play("code0", 3, 1, 1, 0, 1'b0);

    repeat (3) step();
    code = 16'h1111;
    req  = 4'b1111;
    play("rr0", 0, 1, 1, 0, 1'b1);
    play("rr1", 1, 1, 1, 0, 1'b1);
    play("rr2", 2, 1, 1, 0, 1'b1);
    play("rr3", 3, 1, 1, 0, 1'b1);
    play("rr4", 0, 1, 1, 0, 1'b0);
    req = 4'b0;

    repeat (3) step();
    req  = 4'b0010;
    code = 16'h0020;
    play("drop", 1, 2, 1, 5, 1'b0);

    repeat (3) step();
    req  = 4'b0001;
    code = 16'h0003;
    n = 0;
    while (n < 20) begin
      step();
      n++;
      if (grant != 4'b0) break;
    end
    chk("rst_grant", grant, 4'b0001);
    repeat (35) step();
    Reset_n = 1'b0;
    #1;
    chk("rst_mid", {ack, grant, busy, LED2, LED1}, {4'b0, 4'b0, 1'b0, 1'b1, 1'b0});
    req = 4'b0;
    step();
    step();
    chk("rst_hold", {ack, grant, busy, LED2, LED1}, {4'b0, 4'b0, 1'b0, 1'b1, 1'b0});
    Reset_n = 1'b1;
    hb_check("hb_after_rst", 120);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
